// File: rtl/mult_div_seq.sv
// Iterative multiply/divide unit: one shift-add or restoring shift-subtract step per cycle,
// with sign correction and a held HI/LO result behind a start/busy/done handshake.
module mult_div_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             mult_overflow,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH:0]     rem_q, rem_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               ovf_q, ovf_d, dbz_q, dbz_d;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag, addend;
  logic [WIDTH:0]     msum, rem_sh, trial;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  // Signed ops work on magnitudes; |most-negative| still fits as an unsigned WIDTH-bit value.
  assign a_neg  = ~op[0] & a[WIDTH-1];
  assign b_neg  = ~op[0] & b[WIDTH-1];
  assign a_mag  = a_neg ? -a : a;
  assign b_mag  = b_neg ? -b : b;

  assign addend = acc_q[0] ? dvs_q : {WIDTH{1'b0}};
  assign msum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
  assign rem_sh = {rem_q[WIDTH-1:0], acc_q[WIDTH-1]};
  assign trial  = rem_sh - {1'b0, dvs_q};

  assign prod_fix = neg_res_q ? -acc_q : acc_q;
  assign quo_fix  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = neg_rem_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dvs_d     = dvs_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    ovf_d     = ovf_q;
    dbz_d     = dbz_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d  = op;
          ovf_d = 1'b0;
          dbz_d = 1'b0;
          if (op[1] && (b == {WIDTH{1'b0}})) begin
            dbz_d   = 1'b1;
            state_d = DONE;
          end else begin
            neg_res_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            cnt_d     = '0;
            rem_d     = '0;
            state_d   = CALC;
            // Low half of acc holds the multiplier or the dividend, shifted out one bit per step.
            if (op[1]) begin
              acc_d = {{WIDTH{1'b0}}, a_mag};
              dvs_d = b_mag;
            end else begin
              acc_d = {{WIDTH{1'b0}}, b_mag};
              dvs_d = a_mag;
            end
          end
        end
      end
      CALC: begin
        if (op_q[1]) begin
          rem_d = trial[WIDTH] ? rem_sh : trial;
          acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], ~trial[WIDTH]};
        end else begin
          acc_d = {msum, acc_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = FIX;
      end
      FIX: begin
        if (op_q[1]) begin
          hi_d  = rem_fix;
          lo_d  = quo_fix;
          ovf_d = 1'b0;
        end else begin
          hi_d  = prod_fix[2*WIDTH-1:WIDTH];
          lo_d  = prod_fix[WIDTH-1:0];
          ovf_d = op_q[0] ? (prod_fix[2*WIDTH-1:WIDTH] != {WIDTH{1'b0}})
                          : (prod_fix[2*WIDTH-1:WIDTH] != {WIDTH{prod_fix[WIDTH-1]}});
        end
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dvs_q     <= '0;
      acc_q     <= '0;
      rem_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      ovf_q     <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dvs_q     <= dvs_d;
      acc_q     <= acc_d;
      rem_q     <= rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      ovf_q     <= ovf_d;
      dbz_q     <= dbz_d;
    end
  end

  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE);
  assign hi            = hi_q;
  assign lo            = lo_q;
  assign mult_overflow = ovf_q;
  assign div_by_zero   = dbz_q;

endmodule

// File: tb/tb_mult_div_seq.sv
// Directed-vector bench for mult_div_seq (WIDTH=32): results, flags, latency,
// busy-start rejection, back-to-back issue and asynchronous reset abort.
module tb_mult_div_seq;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done, mult_overflow, div_by_zero;
  logic [W-1:0] hi, lo;

  int checks = 0;
  int failures = 0;

  mult_div_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo),
    .mult_overflow(mult_overflow), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Issue one op; if inj>0, pulse start with other operands at that cycle of the run.
  // Returns at #1 after the edge where done is first seen high.
  task automatic do_op(input string tag, input logic [1:0] o, input logic [W-1:0] x,
                       input logic [W-1:0] y, input int inj, input int exp_lat);
    int lat;
    bit ok;
    op = o; a = x; b = y; start = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 4 && !ok; i++) begin
      @(posedge clk); #1;
      if (busy) ok = 1'b1;
    end
    start = 1'b0;
    chk({tag, "_accept"}, 64'(ok), 64'd1);
    lat = 1;
    while (!done && lat < 100) begin
      if (lat == inj) begin
        start = 1'b1; op = ~o; a = 32'h0000_1234; b = 32'h0000_0005;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    $display("op=%s a=%h b=%h lat=%0d hi=%h lo=%h ovf=%b dbz=%b",
             tag, x, y, lat, hi, lo, mult_overflow, div_by_zero);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    chk("rst_flags", {62'd0, mult_overflow, div_by_zero}, 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // mult signed -3 * 7
    do_op("mul_s", 2'b00, -32'sd3, 32'd7, 0, 34);
    chk("mul_s_done", 64'(done), 64'd1);
    chk("mul_s_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);
    chk("mul_s_ovf", 64'(mult_overflow), 64'd0);
    @(posedge clk); #1;
    chk("mul_s_pulse", {62'd0, done, busy}, 64'd0);

    do_op("mul_u", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 34);
    chk("mul_u_hilo", {hi, lo}, 64'hFFFFFFFE_00000001);
    chk("mul_u_ovf", 64'(mult_overflow), 64'd1);

    // 2^16 * 2^16 signed overflows into hi
    do_op("mul_sovf", 2'b00, 32'h0001_0000, 32'h0001_0000, 0, 34);
    chk("mul_sovf_hilo", {hi, lo}, 64'h00000001_00000000);
    chk("mul_sovf_ovf", 64'(mult_overflow), 64'd1);

    do_op("div_s", 2'b10, -32'sd7, 32'd2, 0, 34);
    chk("div_s_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
    chk("div_s_ovf", 64'(mult_overflow), 64'd0);
    // back-to-back: start raised during the DONE cycle
    do_op("div_u", 2'b11, 32'd7, 32'd2, 0, 34);
    chk("div_u_hilo", {hi, lo}, {32'd1, 32'd3});

    do_op("div_pre", 2'b11, 32'd59, 32'd6, 0, 34);
    chk("div_pre_hilo", {hi, lo}, {32'd5, 32'd9});
    do_op("div_z", 2'b11, 32'd1, 32'd0, 0, 1);
    chk("div_z_dbz", 64'(div_by_zero), 64'd1);
    chk("div_z_hilo", {hi, lo}, {32'd5, 32'd9});
    chk("div_z_ovf", 64'(mult_overflow), 64'd0);
    @(posedge clk); #1;
    chk("div_z_hold", {61'd0, done, busy, div_by_zero}, 64'd1);

    // start pulsed mid-CALC must be ignored
    do_op("mul_inj", 2'b00, 32'd100, -32'sd3, 5, 34);
    chk("mul_inj_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFED4);
    chk("mul_inj_dbz", 64'(div_by_zero), 64'd0);
    do_op("div_min", 2'b10, 32'h80000000, 32'hFFFFFFFF, 10, 34);
    chk("div_min_hilo", {hi, lo}, 64'h00000000_80000000);
    chk("div_min_flags", {62'd0, mult_overflow, div_by_zero}, 64'd0);

    // reset during CALC step 10
    @(posedge clk); #1;
    op = 2'b00; a = 32'd1000; b = 32'd1000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("abort_busy0", 64'(busy), 64'd1);
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_hilo", {hi, lo}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("abort_nodone", {62'd0, done, busy}, 64'd0);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    do_op("mul_67", 2'b00, 32'd6, 32'd7, 0, 34);
    chk("mul_67_hilo", {hi, lo}, 64'd42);
    chk("mul_67_ovf", 64'(mult_overflow), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
